// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer
// Transaction-level sequencer sitting between the APB register/FIFO side and
// the I2C byte engine. A start request becomes START, address byte, N data
// bytes (popped from the TX FIFO or pushed into the RX FIFO) and STOP, all as
// byte commands, followed by a single-cycle i2c_done pulse.
// Optional feature: define I2C_SEQ_TIMEOUT_EN to abort any command that the
// engine has not completed within TIMEOUT_CYCLES PCLK cycles.

module i2c_txn_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       start,
    input  logic [7:0] slv_addr,
    input  logic [7:0] byte_cnt,
    input  logic       txff_empty,
    input  logic [7:0] txff_data,
    output logic       txff_rd,
    input  logic       rxff_full,
    output logic       rxff_wr,
    output logic [7:0] rxff_data,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_wdata,
    output logic       cmd_mack,
    input  logic       cmd_done,
    input  logic [7:0] cmd_rdata,
    input  logic       cmd_snack,
    output logic       i2c_done,
    output logic       busy,
    output logic       err_nack
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_FETCH,
        S_WRITE,
        S_READ,
        S_PUSH,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    // FETCH sub-phases: request a pop, let the FIFO advance, then capture head
    localparam logic [1:0] FP_REQ  = 2'd0;
    localparam logic [1:0] FP_WAIT = 2'd1;

    state_t     state_q;
    logic [7:0] addr_q;
    logic [7:0] cnt_q;
    logic [7:0] cntDec_d;
    logic [1:0] fetchPhase_q;

    logic       txffRd_q;
    logic       rxffWr_q;
    logic [7:0] rxffData_q;
    logic       cmdValid_q;
    logic [1:0] cmdOp_q;
    logic [7:0] cmdWdata_q;
    logic       cmdMack_q;
    logic       i2cDone_q;
    logic       busy_q;
    logic       errNack_q;

    logic       cmdAccept;
    logic       timeoutHit;

    // A command completes only when the engine reports done while we request
    assign cmdAccept = cmdValid_q & cmd_done;

    // Remaining-byte count after one more byte, saturating at zero
    assign cntDec_d = (cnt_q == 8'd0) ? 8'd0 : (cnt_q - 8'd1);

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] toCnt_q;

    // Count cycles the current command has been outstanding; restarts per command
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            toCnt_q <= 16'd0;
        end else if (!cmdValid_q) begin
            toCnt_q <= 16'd0;
        end else if (toCnt_q != 16'hFFFF) begin
            toCnt_q <= toCnt_q + 16'd1;
        end
    end

    assign timeoutHit = cmdValid_q && !cmd_done && (toCnt_q >= TO_LAST);
`else
    logic [31:0] unusedTimeoutCycles;

    assign unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign timeoutHit          = 1'b0;
`endif

    // Transaction FSM with all outputs registered
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= S_IDLE;
            addr_q       <= 8'd0;
            cnt_q        <= 8'd0;
            fetchPhase_q <= FP_REQ;
            txffRd_q     <= 1'b0;
            rxffWr_q     <= 1'b0;
            rxffData_q   <= 8'd0;
            cmdValid_q   <= 1'b0;
            cmdOp_q      <= OP_START;
            cmdWdata_q   <= 8'd0;
            cmdMack_q    <= 1'b0;
            i2cDone_q    <= 1'b0;
            busy_q       <= 1'b0;
            errNack_q    <= 1'b0;
        end else begin
            txffRd_q  <= 1'b0;
            rxffWr_q  <= 1'b0;
            i2cDone_q <= 1'b0;

            if (timeoutHit) begin
                cmdValid_q   <= 1'b0;
                errNack_q    <= 1'b1;
                i2cDone_q    <= 1'b1;
                fetchPhase_q <= FP_REQ;
                state_q      <= S_DONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            addr_q     <= slv_addr;
                            cnt_q      <= byte_cnt;
                            errNack_q  <= 1'b0;
                            busy_q     <= 1'b1;
                            cmdValid_q <= 1'b1;
                            cmdOp_q    <= OP_START;
                            cmdMack_q  <= 1'b0;
                            state_q    <= S_START;
                        end
                    end

                    S_START: begin
                        if (cmdAccept) begin
                            cmdValid_q <= 1'b0;
                            state_q    <= S_ADDR;
                        end
                    end

                    S_ADDR: begin
                        if (!cmdValid_q) begin
                            cmdValid_q <= 1'b1;
                            cmdOp_q    <= OP_WRITE;
                            cmdWdata_q <= addr_q;
                            cmdMack_q  <= 1'b0;
                        end else if (cmd_done) begin
                            cmdValid_q <= 1'b0;
                            if (cmd_snack) begin
                                errNack_q <= 1'b1;
                                state_q   <= S_STOP;
                            end else if (cnt_q == 8'd0) begin
                                state_q <= S_STOP;
                            end else if (addr_q[0]) begin
                                state_q <= S_READ;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end
                    end

                    S_FETCH: begin
                        case (fetchPhase_q)
                            FP_REQ: begin
                                if (!txff_empty) begin
                                    txffRd_q     <= 1'b1;
                                    fetchPhase_q <= FP_WAIT;
                                end
                            end
                            FP_WAIT: begin
                                fetchPhase_q <= 2'd2;
                            end
                            default: begin
                                cmdWdata_q   <= txff_data;
                                fetchPhase_q <= FP_REQ;
                                state_q      <= S_WRITE;
                            end
                        endcase
                    end

                    S_WRITE: begin
                        if (!cmdValid_q) begin
                            cmdValid_q <= 1'b1;
                            cmdOp_q    <= OP_WRITE;
                            cmdMack_q  <= 1'b0;
                        end else if (cmd_done) begin
                            cmdValid_q <= 1'b0;
                            cnt_q      <= cntDec_d;
                            if (cmd_snack) begin
                                errNack_q <= 1'b1;
                                state_q   <= S_STOP;
                            end else if (cntDec_d == 8'd0) begin
                                state_q <= S_STOP;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end
                    end

                    S_READ: begin
                        if (!cmdValid_q) begin
                            cmdValid_q <= 1'b1;
                            cmdOp_q    <= OP_READ;
                            cmdMack_q  <= (cnt_q <= 8'd1);
                        end else if (cmd_done) begin
                            cmdValid_q <= 1'b0;
                            rxffData_q <= cmd_rdata;
                            state_q    <= S_PUSH;
                        end
                    end

                    S_PUSH: begin
                        if (!rxff_full) begin
                            rxffWr_q <= 1'b1;
                            cnt_q    <= cntDec_d;
                            state_q  <= (cntDec_d == 8'd0) ? S_STOP : S_READ;
                        end
                    end

                    S_STOP: begin
                        if (!cmdValid_q) begin
                            cmdValid_q <= 1'b1;
                            cmdOp_q    <= OP_STOP;
                            cmdMack_q  <= 1'b0;
                        end else if (cmd_done) begin
                            cmdValid_q <= 1'b0;
                            i2cDone_q  <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end

                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end

                    default: begin
                        cmdValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign txff_rd   = txffRd_q;
    assign rxff_wr   = rxffWr_q;
    assign rxff_data = rxffData_q;
    assign cmd_valid = cmdValid_q;
    assign cmd_op    = cmdOp_q;
    assign cmd_wdata = cmdWdata_q;
    assign cmd_mack  = cmdMack_q;
    assign i2c_done  = i2cDone_q;
    assign busy      = busy_q;
    assign err_nack  = errNack_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Testbench for i2c_txn_sequencer: random transactions against a
// transaction-level model, with a scoreboard monitor checking every command,
// RX push and completion. The timeout scenario runs only when the design is
// built with I2C_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps

module tb_i2c_txn_sequencer;

    localparam int TO_CYC = 16;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] slv_addr = 8'd0;
    logic [7:0] byte_cnt = 8'd0;
    logic       txff_empty = 1'b1;
    logic [7:0] txff_data = 8'd0;
    logic       txff_rd;
    logic       rxff_full = 1'b0;
    logic       rxff_wr;
    logic [7:0] rxff_data;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_mack;
    logic       cmd_done = 1'b0;
    logic [7:0] cmd_rdata = 8'd0;
    logic       cmd_snack = 1'b0;
    logic       i2c_done;
    logic       busy;
    logic       err_nack;

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .slv_addr(slv_addr),
        .byte_cnt(byte_cnt), .txff_empty(txff_empty), .txff_data(txff_data),
        .txff_rd(txff_rd), .rxff_full(rxff_full), .rxff_wr(rxff_wr),
        .rxff_data(rxff_data), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .cmd_mack(cmd_mack), .cmd_done(cmd_done),
        .cmd_rdata(cmd_rdata), .cmd_snack(cmd_snack), .i2c_done(i2c_done),
        .busy(busy), .err_nack(err_nack)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [1:0] op;
        logic [7:0] wdata;
        logic       mack;
    } cmd_t;

    typedef struct {
        logic err;
        int   nRd;
    } done_t;

    // Scoreboard queues filled by stimulus, drained by the monitor
    cmd_t       expCmdQ[$];
    logic [7:0] expRxQ[$];
    done_t      expDoneQ[$];

    int nChecks = 0;
    int nFails  = 0;

    // Environment state
    logic [7:0] txQ[$];
    logic [7:0] txHold = 8'd0;
    bit         txPend = 1'b0;
    logic [7:0] engRdQ[$];
    bit         engActive = 1'b0;
    int         engDelay = 0;
    int         engWriteIdx = 0;
    int         engNackIdx = -1;
    bit         engHang = 1'b0;
    bit         rxFullEn = 1'b0;
    bit         monEnable = 1'b1;
    int         totalRd = 0;
    int         txnRd = 0;
    int         doneCount = 0;
    int         validLen = 0;
    int         lastValidLen = 0;
    bit         prevValid = 1'b0;
    bit         prevDone = 1'b0;
    logic [1:0] heldOp = 2'd0;
    cmd_t       expCur;
    done_t      doneCur;
    logic [7:0] rxCur;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input string detail);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".txff_rd"},   txff_rd,   0);
        checkOutput({tag, ".rxff_wr"},   rxff_wr,   0);
        checkOutput({tag, ".rxff_data"}, rxff_data, 0);
        checkOutput({tag, ".cmd_valid"}, cmd_valid, 0);
        checkOutput({tag, ".cmd_op"},    cmd_op,    0);
        checkOutput({tag, ".cmd_wdata"}, cmd_wdata, 0);
        checkOutput({tag, ".cmd_mack"},  cmd_mack,  0);
        checkOutput({tag, ".i2c_done"},  i2c_done,  0);
        checkOutput({tag, ".busy"},      busy,      0);
        checkOutput({tag, ".err_nack"},  err_nack,  0);
    endtask

    // Drivers on the falling edge: TX FIFO, RX full, and the byte engine
    initial begin
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                cmd_done  = 1'b0;
                engActive = 1'b0;
                txPend    = 1'b0;
            end else begin
                if (txPend) begin
                    txff_data = txHold;
                    txPend    = 1'b0;
                end
                if (txff_rd) begin
                    txHold    = (txQ.size() > 0) ? txQ.pop_front() : 8'hEE;
                    txPend    = 1'b1;
                    txff_data = 8'($urandom);
                end
                txff_empty = (txQ.size() == 0);
                rxff_full  = rxFullEn && ($urandom_range(0, 3) == 0);
                if (cmd_done) begin
                    cmd_done  = 1'b0;
                    engActive = 1'b0;
                end else if (cmd_valid && !engHang) begin
                    if (!engActive) begin
                        engActive = 1'b1;
                        engDelay  = $urandom_range(0, 3);
                    end
                    if (engDelay == 0) begin
                        cmd_done  = 1'b1;
                        cmd_snack = 1'b0;
                        cmd_rdata = 8'($urandom);
                        if (cmd_op == 2'd1) begin
                            cmd_snack = (engWriteIdx == engNackIdx);
                            engWriteIdx++;
                        end else if (cmd_op == 2'd2) begin
                            cmd_rdata = (engRdQ.size() > 0) ? engRdQ.pop_front() : 8'h00;
                        end
                    end else begin
                        engDelay--;
                    end
                end
            end
        end
    end

    // Monitor: compare DUT activity against the scoreboard just after each edge
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            if (!PRESETn) begin
                prevValid = 1'b0;
                prevDone  = 1'b0;
            end else begin
                if (txff_rd) begin
                    totalRd++;
                    txnRd++;
                end
                if (monEnable) begin
                    if (cmd_valid && !prevValid) begin
                        validLen = 0;
                        heldOp   = cmd_op;
                        if (expCmdQ.size() == 0) begin
                            failNow("cmdUnexpected", $sformatf("got op %0d, expected no command", cmd_op));
                        end else begin
                            expCur = expCmdQ.pop_front();
                            checkOutput("cmdOp", cmd_op, expCur.op);
                            if (expCur.op == 2'd1) checkOutput("cmdWdata", cmd_wdata, expCur.wdata);
                            if (expCur.op == 2'd2) checkOutput("cmdMack", cmd_mack, expCur.mack);
                        end
                    end else if (cmd_valid && prevValid) begin
                        checkOutput("cmdOpStable", cmd_op, heldOp);
                    end
                    if (rxff_wr) begin
                        checkOutput("rxWrWhileFull", rxff_full, 0);
                        if (expRxQ.size() == 0) begin
                            failNow("rxUnexpected", $sformatf("got push 0x%0h, expected none", rxff_data));
                        end else begin
                            rxCur = expRxQ.pop_front();
                            checkOutput("rxData", rxff_data, rxCur);
                        end
                    end
                    if (i2c_done) begin
                        checkOutput("doneOneCycle", prevDone, 0);
                        if (expDoneQ.size() == 0) begin
                            failNow("doneUnexpected", "got i2c_done, expected none");
                        end else begin
                            doneCur = expDoneQ.pop_front();
                            checkOutput("errNack", err_nack, doneCur.err);
                            checkOutput("txPops", txnRd, doneCur.nRd);
                            checkOutput("cmdsLeft", expCmdQ.size(), 0);
                            checkOutput("rxLeft", expRxQ.size(), 0);
                            checkOutput("busyAtDone", busy, 1);
                        end
                        txnRd = 0;
                        doneCount++;
                    end
                end
                if (cmd_valid) validLen++;
                else if (prevValid) lastValidLen = validLen;
                prevValid = cmd_valid;
                prevDone  = i2c_done;
            end
        end
    end

    // Build the expected command stream for one transaction and run it
    task automatic applyStimulus(input logic [7:0] addr, input int cnt, input int nackIdx,
                                 input bit stall, input bit pokeBusy, input bit hang);
        logic [7:0] tx[$];
        logic [7:0] rd[$];
        cmd_t       c;
        done_t      d;
        int         startDone;
        int         baseRd;
        int         stallCnt = 0;
        bit         stallFed = 1'b0;
        bit         isRead = addr[0];

        d.err = 1'b0;
        d.nRd = 0;
        for (int i = 0; i < cnt; i++) begin
            tx.push_back(8'($urandom));
            rd.push_back(8'($urandom));
        end

        c = '{2'd0, 8'd0, 1'b0};
        expCmdQ.push_back(c);
        if (hang) begin
            d.err = 1'b1;
        end else begin
            c = '{2'd1, addr, 1'b0};
            expCmdQ.push_back(c);
            if (nackIdx == 0) begin
                d.err = 1'b1;
            end else if (isRead) begin
                for (int i = 0; i < cnt; i++) begin
                    c = '{2'd2, 8'd0, (i == cnt - 1)};
                    expCmdQ.push_back(c);
                    expRxQ.push_back(rd[i]);
                end
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    c = '{2'd1, tx[i], 1'b0};
                    expCmdQ.push_back(c);
                    d.nRd++;
                    if (nackIdx == i + 1) begin
                        d.err = 1'b1;
                        break;
                    end
                end
            end
            c = '{2'd3, 8'd0, 1'b0};
            expCmdQ.push_back(c);
        end
        expDoneQ.push_back(d);

        engWriteIdx = 0;
        engNackIdx  = nackIdx;
        engHang     = hang;
        engRdQ      = rd;
        if (!isRead) begin
            for (int i = 0; i < cnt; i++) begin
                if (!stall || i == 0) txQ.push_back(tx[i]);
            end
        end

        startDone = doneCount;
        baseRd    = totalRd;
        @(negedge PCLK);
        slv_addr = addr;
        byte_cnt = 8'(cnt);
        start    = 1'b1;
        @(negedge PCLK);
        start    = 1'b0;
        slv_addr = 8'($urandom);
        byte_cnt = 8'($urandom);

        for (int cyc = 0; cyc < 6000 && doneCount == startDone; cyc++) begin
            @(negedge PCLK);
            start = pokeBusy && (cyc == 3);
            if (stall && !stallFed && totalRd > baseRd) begin
                stallCnt++;
                if (stallCnt == 10) begin
                    checkOutput("stallNoCmd", cmd_valid, 0);
                    checkOutput("stallBusy", busy, 1);
                    checkOutput("stallOnePop", totalRd - baseRd, 1);
                    for (int i = 1; i < cnt; i++) txQ.push_back(tx[i]);
                    stallFed = 1'b1;
                end
            end
        end
        start = 1'b0;
        if (doneCount == startDone) begin
            failNow("doneTimeout", $sformatf("no i2c_done for addr 0x%0h cnt %0d", addr, cnt));
        end
        @(negedge PCLK);
        checkOutput("idleBusy", busy, 0);
        if (hang) checkOutput("timeoutValidLen", lastValidLen, TO_CYC);
        engHang = 1'b0;
        txQ.delete();
        engRdQ.delete();
        expCmdQ.delete();
        expRxQ.delete();
        expDoneQ.delete();
    endtask

    // Directed scenarios, randomized transactions and mid-transaction reset
    initial begin
        int baseRd;
        bit hit;

        repeat (3) @(negedge PCLK);
        checkAllZero("inReset");
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        checkAllZero("afterReset");

        $display("[TB] directed transactions");
        applyStimulus(8'hA0, 2, -1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA1, 3, -1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA0, 4,  0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA0, 2, -1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hA0, 0, -1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA1, 0, -1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA0, 3, -1, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h42, 4,  2, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA1, 255, -1, 1'b0, 1'b0, 1'b0);

        $display("[TB] random transactions");
        rxFullEn = 1'b1;
        for (int t = 0; t < 14; t++) begin
            automatic logic [7:0] a = 8'($urandom);
            automatic int c = $urandom_range(0, 6);
            automatic int nk = -1;
            if (!a[0] && $urandom_range(0, 2) == 0) nk = $urandom_range(0, c);
            if (a[0] && $urandom_range(0, 4) == 0) nk = 0;
            applyStimulus(a, c, nk, 1'b0, (t % 4) == 1, 1'b0);
        end
        rxFullEn = 1'b0;

        $display("[TB] reset during WRITE");
        monEnable   = 1'b0;
        engWriteIdx = 0;
        engNackIdx  = -1;
        for (int i = 0; i < 3; i++) txQ.push_back(8'($urandom));
        baseRd = totalRd;
        @(negedge PCLK);
        slv_addr = 8'hA0;
        byte_cnt = 8'd3;
        start    = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
        hit   = 1'b0;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(negedge PCLK);
            hit = (totalRd > baseRd) && cmd_valid && (cmd_op == 2'd1);
        end
        if (!hit) failNow("reachWrite", "data WRITE command never observed");
        PRESETn = 1'b0;
        #1;
        checkAllZero("midReset");
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        txQ.delete();
        txnRd     = 0;
        monEnable = 1'b1;
        applyStimulus(8'hA0, 2, -1, 1'b0, 1'b0, 1'b0);

`ifdef I2C_SEQ_TIMEOUT_EN
        $display("[TB] engine timeout");
        applyStimulus(8'hA0, 2, -1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hA1, 1, -1, 1'b0, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global watchdog in case something outside the bounded waits stalls
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
